imm_ext_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator between decode and execute.

---
 rtl/imm_ext_pipe_if.sv | 35 +++
 rtl/imm_ext_pipe.sv | 195 +++++++++++++++++++
 tb/tb_imm_ext_pipe.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe_if
//   Bundles the two valid/ready streams of imm_ext_pipe: the decode-side input
//   (instruction, immediate select, tag) and the execute-side output (extended
//   immediate, tag, illegal flag).
//   Parameters: XLEN  output immediate width (32 or 64)
//               TAG_W sideband tag width
//   Modports:   master  producer of in_*, consumer of out_* (decode/execute)
//               slave   the immediate pipe itself
// -----------------------------------------------------------------------------
interface imm_ext_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [2:0]       in_imm_src;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_imm_src, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//   Pipelined RISC-V immediate generator sitting between decode and execute.
//   Decodes the I/S/B/U/J (and optionally Z) immediate of an instruction word,
//   sign-extends it to XLEN and presents it one cycle after acceptance, with a
//   sideband tag and an illegal-select flag.
//
//   Parameters:
//     XLEN   output immediate width, 32 or 64
//     TAG_W  sideband tag width
//     SKID   1: two-entry skid buffer, registered in_ready, full throughput
//            0: single register, in_ready = !out_valid || out_ready
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, discards all contents
//     flush  synchronous flush; drops stored entries and any input offered
//     bus    imm_ext_pipe_if.slave: in_valid/in_ready/in_instr/in_imm_src/
//            in_tag and out_valid/out_ready/out_imm/out_tag/out_illegal
//
//   Build option:
//     IMM_EXT_ZICSR_EN  when defined, select 101 returns the zero-extended
//                       CSR uimm (Instr[19:15]); otherwise 101 is illegal.
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int SKID  = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   imm_ext_pipe_if.slave bus
);
   // Occupancy encoding {main_v, skid_v}
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_TWO   = 2'b11;

   localparam logic [2:0] SRC_I = 3'b000;
   localparam logic [2:0] SRC_S = 3'b001;
   localparam logic [2:0] SRC_B = 3'b010;
   localparam logic [2:0] SRC_U = 3'b011;
   localparam logic [2:0] SRC_J = 3'b100;
   localparam logic [2:0] SRC_Z = 3'b101;

   logic [31:0]      imm32;
   logic             zimm_sel;
   logic             ext_illegal;
   logic [XLEN-1:0]  ext_imm;
   logic             unused_opcode;

   logic             main_v_reg;
   logic [XLEN-1:0]  main_imm_reg;
   logic [TAG_W-1:0] main_tag_reg;
   logic             main_ill_reg;

   logic             in_ready;
   logic             accept;
   logic             drain;

   // Every format is first built as a 32-bit value whose bit 31 is the
   // instruction sign bit, so one signed cast covers both XLEN=32 and the
   // RV64 rule that the upper word replicates the sign.
   always_comb begin
      imm32       = '0;
      zimm_sel    = 1'b0;
      ext_illegal = 1'b0;
      case (bus.in_imm_src)
         SRC_I: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
         SRC_S: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
         SRC_B: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                         bus.in_instr[11:8], 1'b0};
         SRC_U: imm32 = {bus.in_instr[31:12], 12'b0};
         SRC_J: imm32 = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                         bus.in_instr[30:21], 1'b0};
`ifdef IMM_EXT_ZICSR_EN
         SRC_Z: zimm_sel = 1'b1;
`else
         SRC_Z: ext_illegal = 1'b1;
`endif
         default: ext_illegal = 1'b1;
      endcase
      // Illegal selects leave imm32 at zero, so out_imm is forced to 0.
      ext_imm = zimm_sel ? XLEN'(bus.in_instr[19:15]) : XLEN'(signed'(imm32));
   end

   // Opcode bits never feed any immediate format.
   assign unused_opcode = ^bus.in_instr[6:0];

   assign accept = bus.in_valid && in_ready;
   assign drain  = main_v_reg && bus.out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic             skid_v_reg;
         logic             in_ready_reg;
         logic [XLEN-1:0]  skid_imm_reg;
         logic [TAG_W-1:0] skid_tag_reg;
         logic             skid_ill_reg;

         // in_ready_reg always equals !skid_v_reg; keeping it as its own flop
         // takes the output off any combinational path from out_ready.
         assign in_ready = in_ready_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               main_v_reg   <= 1'b0;
               main_imm_reg <= '0;
               main_tag_reg <= '0;
               main_ill_reg <= 1'b0;
               skid_v_reg   <= 1'b0;
               skid_imm_reg <= '0;
               skid_tag_reg <= '0;
               skid_ill_reg <= 1'b0;
               in_ready_reg <= 1'b1;
            end else if (flush) begin
               // Payload is left as-is; it is meaningless once valid drops.
               main_v_reg   <= 1'b0;
               skid_v_reg   <= 1'b0;
               in_ready_reg <= 1'b1;
            end else begin
               case ({main_v_reg, skid_v_reg})
                  ST_EMPTY: begin
                     if (accept) begin
                        main_v_reg   <= 1'b1;
                        main_imm_reg <= ext_imm;
                        main_tag_reg <= bus.in_tag;
                        main_ill_reg <= ext_illegal;
                     end
                  end
                  ST_ONE: begin
                     if (accept && drain) begin
                        main_imm_reg <= ext_imm;
                        main_tag_reg <= bus.in_tag;
                        main_ill_reg <= ext_illegal;
                     end else if (accept) begin
                        // Consumer stalled: park the newcomer behind main.
                        skid_v_reg   <= 1'b1;
                        skid_imm_reg <= ext_imm;
                        skid_tag_reg <= bus.in_tag;
                        skid_ill_reg <= ext_illegal;
                        in_ready_reg <= 1'b0;
                     end else if (drain) begin
                        main_v_reg   <= 1'b0;
                     end
                  end
                  ST_TWO: begin
                     // in_ready is low here, so only a drain can happen.
                     if (drain) begin
                        main_imm_reg <= skid_imm_reg;
                        main_tag_reg <= skid_tag_reg;
                        main_ill_reg <= skid_ill_reg;
                        skid_v_reg   <= 1'b0;
                        in_ready_reg <= 1'b1;
                     end
                  end
                  default: begin
                     // Skid without main cannot occur; recover to empty.
                     main_v_reg   <= 1'b0;
                     skid_v_reg   <= 1'b0;
                     in_ready_reg <= 1'b1;
                  end
               endcase
            end
         end
      end else begin : g_single
         assign in_ready = !main_v_reg || bus.out_ready;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               main_v_reg   <= 1'b0;
               main_imm_reg <= '0;
               main_tag_reg <= '0;
               main_ill_reg <= 1'b0;
            end else if (flush) begin
               main_v_reg   <= 1'b0;
            end else if (accept) begin
               main_v_reg   <= 1'b1;
               main_imm_reg <= ext_imm;
               main_tag_reg <= bus.in_tag;
               main_ill_reg <= ext_illegal;
            end else if (drain) begin
               main_v_reg   <= 1'b0;
            end
         end
      end
   endgenerate

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = main_v_reg;
   assign bus.out_imm     = main_imm_reg;
   assign bus.out_tag     = main_tag_reg;
   assign bus.out_illegal = main_ill_reg;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe
//   Two instances: dut_a (XLEN=32, SKID=1) and dut_b (XLEN=64, SKID=0).
//   Expected results are pushed to per-instance queues when an input transfer
//   is seen and popped when an output transfer is seen. Directed steps cover
//   the reference vectors, skid fill/drain, flush and illegal selects, then a
//   random valid/ready/flush stream with a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;
   typedef struct packed {
      logic        ill;
      logic [4:0]  tag;
      logic [63:0] imm;
   } exp_t;

`ifdef IMM_EXT_ZICSR_EN
   localparam bit ZICSR = 1'b1;
`else
   localparam bit ZICSR = 1'b0;
`endif
   localparam int N_RAND = 10000;

   logic clk = 1'b0;
   logic rst_n;
   logic flush_a;
   logic flush_b;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imm_ext_pipe_if #(.XLEN(32), .TAG_W(5)) ia ();
   imm_ext_pipe_if #(.XLEN(64), .TAG_W(5)) ib ();

   imm_ext_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_a),
      .bus   (ia)
   );

   imm_ext_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_b),
      .bus   (ib)
   );

   // Reference immediate, always computed at 64 bits; the 32-bit instance
   // compares against the low word.
   function automatic exp_t model(input logic [31:0] i, input logic [2:0] src, input logic [4:0] tag);
      exp_t e;
      logic s;
      s     = i[31];
      e.tag = tag;
      e.ill = 1'b0;
      case (src)
         3'd0: e.imm = {{52{s}}, i[31:20]};
         3'd1: e.imm = {{52{s}}, i[31:25], i[11:7]};
         3'd2: e.imm = {{52{s}}, i[7], i[30:25], i[11:8], 1'b0};
         3'd3: e.imm = {{32{s}}, i[31:12], 12'b0};
         3'd4: e.imm = {{44{s}}, i[19:12], i[20], i[30:21], 1'b0};
         3'd5: begin
            e.imm = ZICSR ? {59'b0, i[19:15]} : 64'b0;
            e.ill = !ZICSR;
         end
         default: begin
            e.imm = 64'b0;
            e.ill = 1'b1;
         end
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv_a(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
      ia.in_valid   = v;
      ia.in_instr   = ins;
      ia.in_imm_src = src;
      ia.in_tag     = tag;
   endtask

   task automatic drv_b(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
      ib.in_valid   = v;
      ib.in_instr   = ins;
      ib.in_imm_src = src;
      ib.in_tag     = tag;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboards / monitors ----------------
   exp_t         q_a[$];
   exp_t         q_b[$];
   exp_t         e_a;
   exp_t         e_b;
   logic         hold_a = 1'b0;
   logic         hold_b = 1'b0;
   logic [69:0]  snap_a;
   logic [69:0]  snap_b;

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         q_a.delete();
         hold_a = 1'b0;
      end else begin
         if (hold_a) begin
            chk("a_stall_valid", 128'(ia.out_valid), 128'(1'b1));
            chk("a_stall_data", 128'({ia.out_illegal, ia.out_tag, ia.out_imm}), 128'(snap_a));
         end
         if (ia.out_valid === 1'b1 && ia.out_ready === 1'b1) begin
            chk("a_out_expected", 128'(q_a.size() > 0), 128'(1'b1));
            if (q_a.size() > 0) begin
               e_a = q_a.pop_front();
               chk("a_out", 128'({ia.out_illegal, ia.out_tag, ia.out_imm}),
                   128'({e_a.ill, e_a.tag, e_a.imm[31:0]}));
               $display("a out tag=%0d imm=%h ill=%0b", ia.out_tag, ia.out_imm, ia.out_illegal);
            end
         end
         hold_a = (ia.out_valid === 1'b1) && (ia.out_ready === 1'b0) && (flush_a === 1'b0);
         snap_a = 70'({ia.out_illegal, ia.out_tag, ia.out_imm});
         if (flush_a === 1'b1)
            q_a.delete();
         else if (ia.in_valid === 1'b1 && ia.in_ready === 1'b1)
            q_a.push_back(model(ia.in_instr, ia.in_imm_src, ia.in_tag));
      end
   end

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         q_b.delete();
         hold_b = 1'b0;
      end else begin
         if (hold_b) begin
            chk("b_stall_valid", 128'(ib.out_valid), 128'(1'b1));
            chk("b_stall_data", 128'({ib.out_illegal, ib.out_tag, ib.out_imm}), 128'(snap_b));
         end
         if (ib.out_valid === 1'b1 && ib.out_ready === 1'b1) begin
            chk("b_out_expected", 128'(q_b.size() > 0), 128'(1'b1));
            if (q_b.size() > 0) begin
               e_b = q_b.pop_front();
               chk("b_out", 128'({ib.out_illegal, ib.out_tag, ib.out_imm}),
                   128'({e_b.ill, e_b.tag, e_b.imm}));
               $display("b out tag=%0d imm=%h ill=%0b", ib.out_tag, ib.out_imm, ib.out_illegal);
            end
         end
         hold_b = (ib.out_valid === 1'b1) && (ib.out_ready === 1'b0) && (flush_b === 1'b0);
         snap_b = {ib.out_illegal, ib.out_tag, ib.out_imm};
         if (flush_b === 1'b1)
            q_b.delete();
         else if (ib.in_valid === 1'b1 && ib.in_ready === 1'b1)
            q_b.push_back(model(ib.in_instr, ib.in_imm_src, ib.in_tag));
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int   sent_a;
      int   sent_b;
      logic acc_a;
      logic acc_b;
      logic fl_a;
      logic fl_b;

      rst_n   = 1'b1;
      flush_a = 1'b0;
      flush_b = 1'b0;
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      drv_b(1'b0, 32'h0, 3'd0, 5'd0);
      ia.out_ready = 1'b0;
      ib.out_ready = 1'b0;

      // Reset state while rst_n is low
      #2 rst_n = 1'b0;
      #1;
      chk("rst_a_valid",   128'(ia.out_valid),   128'(1'b0));
      chk("rst_a_ready",   128'(ia.in_ready),    128'(1'b1));
      chk("rst_a_imm",     128'(ia.out_imm),     128'(0));
      chk("rst_a_tag",     128'(ia.out_tag),     128'(0));
      chk("rst_a_illegal", 128'(ia.out_illegal), 128'(1'b0));
      chk("rst_b_valid",   128'(ib.out_valid),   128'(1'b0));
      chk("rst_b_ready",   128'(ib.in_ready),    128'(1'b1));
      chk("rst_b_imm",     128'(ib.out_imm),     128'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("post_rst_a_ready", 128'(ia.in_ready), 128'(1'b1));
      chk("post_rst_b_ready", 128'(ib.in_ready), 128'(1'b1));

      // addi x1,x0,-1 on the 32-bit instance, one cycle latency
      ia.out_ready = 1'b1;
      drv_a(1'b1, 32'hFFF00093, 3'd0, 5'd1);
      step();
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t1_valid", 128'(ia.out_valid), 128'(1'b1));
      chk("t1_imm",   128'(ia.out_imm),   128'(32'hFFFFFFFF));
      step();
      chk("t1_idle",  128'(ia.out_valid), 128'(1'b0));

      // RV64 U and J, back to back through the single-stage instance
      ib.out_ready = 1'b1;
      drv_b(1'b1, 32'h800000B7, 3'd3, 5'd2);
      step();
      drv_b(1'b1, 32'h0080006F, 3'd4, 5'd3);
      chk("t2_u_imm", 128'(ib.out_imm), 128'(64'hFFFFFFFF80000000));
      step();
      drv_b(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t2_j_valid", 128'(ib.out_valid), 128'(1'b1));
      chk("t2_j_imm",   128'(ib.out_imm),   128'(64'h8));
      step();
      chk("t2_idle", 128'(ib.out_valid), 128'(1'b0));

      // Skid fill with the consumer stalled, then drain in order
      ia.out_ready = 1'b0;
      drv_a(1'b1, 32'hFE000EE3, 3'd2, 5'd1);
      step();
      chk("t3_ready_one", 128'(ia.in_ready), 128'(1'b1));
      drv_a(1'b1, 32'h00000463, 3'd2, 5'd2);
      step();
      chk("t3_ready_fall", 128'(ia.in_ready), 128'(1'b0));
      drv_a(1'b1, 32'h80000063, 3'd2, 5'd3);
      step();
      step();
      chk("t3_hold_ready", 128'(ia.in_ready), 128'(1'b0));
      chk("t3_head_tag",   128'(ia.out_tag),  128'(5'd1));
      chk("t3_head_imm",   128'(ia.out_imm),  128'(32'hFFFFFFFC));
      ia.out_ready = 1'b1;
      step();
      chk("t3_tag2",       128'(ia.out_tag),   128'(5'd2));
      chk("t3_tag2_valid", 128'(ia.out_valid), 128'(1'b1));
      chk("t3_ready_back", 128'(ia.in_ready),  128'(1'b1));
      step();
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t3_tag3",       128'(ia.out_tag),   128'(5'd3));
      chk("t3_tag3_valid", 128'(ia.out_valid), 128'(1'b1));
      step();
      chk("t3_empty", 128'(ia.out_valid), 128'(1'b0));
      chk("t3_queue", 128'(q_a.size()),   128'(0));

      // Flush while full (TWO) with an input offered
      ia.out_ready = 1'b0;
      drv_a(1'b1, 32'h00500093, 3'd0, 5'd4);
      step();
      drv_a(1'b1, 32'h00600093, 3'd0, 5'd5);
      step();
      chk("t4_two_ready", 128'(ia.in_ready), 128'(1'b0));
      drv_a(1'b1, 32'h00700093, 3'd0, 5'd6);
      flush_a = 1'b1;
      step();
      flush_a = 1'b0;
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t4_valid", 128'(ia.out_valid), 128'(1'b0));
      chk("t4_ready", 128'(ia.in_ready),  128'(1'b1));
      ia.out_ready = 1'b1;
      drv_a(1'b1, 32'h00100093, 3'd0, 5'd7);
      step();
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t4_next_tag", 128'(ia.out_tag), 128'(5'd7));
      chk("t4_next_imm", 128'(ia.out_imm), 128'(32'h1));
      step();
      chk("t4_queue", 128'(q_a.size()), 128'(0));

      // Flush beats a simultaneous accept on the single-stage instance
      ib.out_ready = 1'b0;
      drv_b(1'b1, 32'h00A00093, 3'd0, 5'd10);
      step();
      ib.out_ready = 1'b1;
      drv_b(1'b1, 32'h00B00093, 3'd0, 5'd11);
      flush_b = 1'b1;
      step();
      flush_b = 1'b0;
      drv_b(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t4b_valid", 128'(ib.out_valid), 128'(1'b0));
      chk("t4b_ready", 128'(ib.in_ready),  128'(1'b1));
      chk("t4b_queue", 128'(q_b.size()),   128'(0));

      // CSR uimm select
      drv_b(1'b1, 32'h0002D073, 3'd5, 5'd12);
      step();
      drv_b(1'b0, 32'h0, 3'd0, 5'd0);
      chk("t5_imm", 128'(ib.out_imm),     ZICSR ? 128'(5) : 128'(0));
      chk("t5_ill", 128'(ib.out_illegal), ZICSR ? 128'(0) : 128'(1));
      chk("t5_tag", 128'(ib.out_tag),     128'(5'd12));
      step();

      // Always-illegal selects 110 and 111
      ia.out_ready = 1'b1;
      drv_a(1'b1, 32'hFFFFFFFF, 3'd6, 5'd13);
      step();
      drv_a(1'b1, 32'hFFFFFFFF, 3'd7, 5'd14);
      chk("ill6_imm", 128'(ia.out_imm),     128'(0));
      chk("ill6_ill", 128'(ia.out_illegal), 128'(1'b1));
      chk("ill6_tag", 128'(ia.out_tag),     128'(5'd13));
      step();
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      chk("ill7_imm", 128'(ia.out_imm),     128'(0));
      chk("ill7_ill", 128'(ia.out_illegal), 128'(1'b1));
      chk("ill7_tag", 128'(ia.out_tag),     128'(5'd14));
      step();

      // Random valid/ready/flush stream with a mid-stream reset
      sent_a = 0;
      sent_b = 0;
      for (int cyc = 0; cyc < 60000 && (sent_a < N_RAND || sent_b < N_RAND); cyc++) begin
         @(negedge clk);
         acc_a = ia.in_valid && ia.in_ready;
         acc_b = ib.in_valid && ib.in_ready;
         fl_a  = flush_a;
         fl_b  = flush_b;
         @(posedge clk);
         #1;
         if (acc_a) sent_a++;
         if (acc_b) sent_b++;
         if (acc_a || fl_a || !ia.in_valid)
            drv_a((sent_a < N_RAND) && ($urandom_range(3, 0) != 0), $urandom,
                  3'($urandom_range(7, 0)), 5'($urandom));
         if (acc_b || fl_b || !ib.in_valid)
            drv_b((sent_b < N_RAND) && ($urandom_range(3, 0) != 0), $urandom,
                  3'($urandom_range(7, 0)), 5'($urandom));
         ia.out_ready = ($urandom_range(3, 0) != 0);
         ib.out_ready = ($urandom_range(3, 0) != 0);
         flush_a      = ($urandom_range(127, 0) == 0);
         flush_b      = ($urandom_range(127, 0) == 0);
         if (cyc == 5000) begin
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_a_valid", 128'(ia.out_valid), 128'(1'b0));
            chk("mid_rst_a_ready", 128'(ia.in_ready),  128'(1'b1));
            chk("mid_rst_a_imm",   128'(ia.out_imm),   128'(0));
            chk("mid_rst_b_valid", 128'(ib.out_valid), 128'(1'b0));
            chk("mid_rst_b_ready", 128'(ib.in_ready),  128'(1'b1));
            chk("mid_rst_b_tag",   128'(ib.out_tag),   128'(0));
            @(posedge clk);
            #1;
            drv_a(1'b0, 32'h0, 3'd0, 5'd0);
            drv_b(1'b0, 32'h0, 3'd0, 5'd0);
            flush_a = 1'b0;
            flush_b = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end
      chk("rand_count_a", 128'(sent_a >= N_RAND), 128'(1'b1));
      chk("rand_count_b", 128'(sent_b >= N_RAND), 128'(1'b1));

      // Drain what is left
      drv_a(1'b0, 32'h0, 3'd0, 5'd0);
      drv_b(1'b0, 32'h0, 3'd0, 5'd0);
      flush_a      = 1'b0;
      flush_b      = 1'b0;
      ia.out_ready = 1'b1;
      ib.out_ready = 1'b1;
      repeat (4) step();
      chk("drain_a_queue", 128'(q_a.size()),   128'(0));
      chk("drain_b_queue", 128'(q_b.size()),   128'(0));
      chk("drain_a_valid", 128'(ia.out_valid), 128'(1'b0));
      chk("drain_b_valid", 128'(ib.out_valid), 128'(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
